fp16_mul_arbiter: RTL and testbench
===================================

Name: fp16_mul_arbiter

Overview:
- Shares one fp16/int multiplier datapath between NUM_REQ requesters in the E203 accelerator.
- Arbitrates valid/ready requests round-robin and issues one operation per cycle into a 2-stage stall-able pipeline.
- Returns each result with the originating requester ID on a single shared response channel.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester ID field.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*16  operand A, requester i at bits [16i+15:16i]
- req_b  in  NUM_REQ*16  operand B, same packing as req_a
- req_mode  in  NUM_REQ  1 = fp16 multiply, 0 = signed int8 multiply of low bytes
- resp_valid  out  1  result valid
- resp_ready  in  1  consumer accepts result
- resp_data  out  16  product
- resp_id  out  ID_W  index of the requester that issued the operation

Behaviour:
- Reset (async, rst_n=0):
  - resp_valid=0, resp_data=0, resp_id=0, req_ready=0.
  - Stage-1 valid=0; round-robin pointer = NUM_REQ-1, so requester 0 has highest priority first.
- Pipeline:
  - S1 holds registered operands, mode and ID.
  - S2 is the result register that drives the resp_* outputs.
  - advance = !resp_valid | resp_ready.
  - S2 loads from S1 when advance. If S1 is empty, resp_valid clears on a handshake.
  - S1 accepts a new request when !s1_valid | advance.
- Latency: handshake at edge N, resp_valid high after edge N+1 (2 cycles). Throughput is 1 op/cycle while resp_ready=1.
- Arbitration:
  - Combinational round-robin. The search starts at pointer+1 and wraps modulo NUM_REQ.
  - The winner's req_ready=1 only when S1 can accept; otherwise all req_ready=0.
  - The pointer updates to the winner only on a completed handshake.
  - req_ready never depends on the winner's own req_valid going low (no combinational loop through the requester).
- Requester rules: a requester holds valid and operands stable until ready. A dropped valid before handshake is legal; that requester is simply not granted.
- Backpressure:
  - resp_valid=1 with resp_ready=0 freezes S2 and S1, and blocks new grants once S1 is full.
  - resp_data and resp_id stay stable while stalled.
- Simultaneous events: a handshake on both the response and the request side in the same cycle shifts the pipeline and loads S1 in one edge, so no bubble is inserted.
- Datapath (fp16 mode): IEEE half precision, round-to-nearest-even.
  - Subnormal inputs are flushed to zero.
  - Overflow gives ±Inf (0x7C00/0xFC00).
  - Any NaN input gives 0x7E00.
  - Inf × 0 gives 0x7E00.
  - Result sign = sign A xor sign B.
- Datapath (int mode): a[7:0] × b[7:0] signed, giving a 16-bit two's-complement product; upper operand bytes are ignored.
- Reset mid-operation: all in-flight operations are discarded and no response is issued. The pointer returns to its reset value.

Optional Feature:
- Macro: FP_MUL_PERF_CNT_EN.
- Defined, adds two outputs:
  - perf_ops (32 bits): increments on each request handshake.
  - perf_stall (32 bits): increments each cycle resp_valid & !resp_ready.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent and there is no logic overhead.

Decomposition:
- Package fp16_mul_pkg holds:
  - FP16_W=16, EXP_W=5, MAN_W=10, EXP_BIAS=15.
  - Constants FP16_QNAN=16'h7E00, FP16_PINF=16'h7C00.
  - typedef struct mul_op_t {a, b, mode}.
- Sub-module int_fp_mul_core: purely combinational multiplier (mode, a, b → result), instantiated between S1 and S2.
- The arbiter and pipeline control stay in the top module.

Test Plan:
- Single op: req0 a=0x4200 (3.0), b=0x4100 (2.5), mode=1 → resp_data=0x4780 (7.5), resp_id=0, resp_valid exactly 2 cycles after handshake.
- Int mode: req1 a=0x00FD, b=0x0004, mode=0 → resp_data=0xFFF4 (−12), resp_id=1.
- Fairness: all 4 requesters valid continuously, resp_ready=1 → grant order 0,1,2,3,0,1…, one result per cycle, no bubbles.
- Backpressure: resp_ready=0 for 5 cycles with 3 requests pending → resp_data/resp_id frozen, at most 2 ops in flight, no op lost or duplicated after release.
- Special values: 0x7BFF×0x4000 → 0x7C00; 0x7C00×0x0000 → 0x7E00; 0x3C00×0x8000 → 0x8000.
- Reset mid-operation: assert rst_n=0 with S1 and S2 full → resp_valid=0 immediately; after release, req2 alone is granted with no stale response.

Source files
------------

// File: rtl/fp16_mul_pkg.sv
// Shared types and constants for the fp16/int8 multiplier arbiter.
package fp16_mul_pkg;

    localparam int unsigned FP16_W   = 16;
    localparam int unsigned EXP_W    = 5;
    localparam int unsigned MAN_W    = 10;
    localparam int unsigned EXP_BIAS = 15;

    localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;
    localparam logic [FP16_W-1:0] FP16_PINF = 16'h7C00;

    typedef struct packed {
        logic [FP16_W-1:0] a;
        logic [FP16_W-1:0] b;
        logic              mode;
    } mul_op_t;

endpackage

// File: rtl/int_fp_mul_core.sv
// Combinational multiplier: fp16 (RNE, subnormals flushed to zero) or signed int8 of low bytes.
module int_fp_mul_core
    import fp16_mul_pkg::*;
(
    input  logic              i_mode,
    input  logic [FP16_W-1:0] i_a,
    input  logic [FP16_W-1:0] i_b,
    output logic [FP16_W-1:0] o_result
);

    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [MAN_W-1:0]   w_ma, w_mb;
    logic               w_sign;
    logic               w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [21:0]        w_prod;
    logic               w_norm, w_guard, w_sticky;
    logic [MAN_W-1:0]   w_man;
    logic [MAN_W:0]     w_rnd;
    logic signed [7:0]  w_exp;
    logic [FP16_W-1:0]  w_fp_res;
    logic [FP16_W-1:0]  w_int_res;

    always_comb begin
        w_ea     = i_a[14:10];
        w_eb     = i_b[14:10];
        w_ma     = i_a[9:0];
        w_mb     = i_b[9:0];
        w_sign   = i_a[15] ^ i_b[15];
        // exponent 0 covers both zero and subnormal, which are flushed
        w_a_zero = (w_ea == '0);
        w_b_zero = (w_eb == '0);
        w_a_inf  = (w_ea == '1) && (w_ma == '0);
        w_b_inf  = (w_eb == '1) && (w_mb == '0);
        w_a_nan  = (w_ea == '1) && (w_ma != '0);
        w_b_nan  = (w_eb == '1) && (w_mb != '0);

        w_prod   = {11'd0, 1'b1, w_ma} * {11'd0, 1'b1, w_mb};
        w_norm   = w_prod[21];
        w_man    = w_norm ? w_prod[20:11] : w_prod[19:10];
        w_guard  = w_norm ? w_prod[10]    : w_prod[9];
        w_sticky = w_norm ? (|w_prod[9:0]) : (|w_prod[8:0]);
        w_rnd    = {1'b0, w_man} + {10'd0, w_guard & (w_sticky | w_man[0])};
        // mantissa carry-out on rounding bumps the exponent; w_rnd[9:0] is then zero
        w_exp    = $signed({3'b0, w_ea} + {3'b0, w_eb} - 8'(EXP_BIAS)
                           + {7'd0, w_norm} + {7'd0, w_rnd[MAN_W]});

        if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_a_zero && w_b_inf)) begin
            w_fp_res = FP16_QNAN;
        end else if (w_a_inf || w_b_inf) begin
            w_fp_res = {w_sign, FP16_PINF[14:0]};
        end else if (w_a_zero || w_b_zero) begin
            w_fp_res = {w_sign, 15'd0};
        end else if (w_exp >= 8'sd31) begin
            w_fp_res = {w_sign, FP16_PINF[14:0]};
        end else if (w_exp <= 8'sd0) begin
            w_fp_res = {w_sign, 15'd0};
        end else begin
            w_fp_res = {w_sign, w_exp[4:0], w_rnd[MAN_W-1:0]};
        end

        w_int_res = {{8{i_a[7]}}, i_a[7:0]} * {{8{i_b[7]}}, i_b[7:0]};
        o_result  = i_mode ? w_fp_res : w_int_res;
    end

endmodule

// File: rtl/fp16_mul_arbiter.sv
// Round-robin arbiter feeding a 2-stage stall-able fp16/int8 multiply pipeline.
// Optional FP_MUL_PERF_CNT_EN adds perf_ops / perf_stall counters.
module fp16_mul_arbiter
    import fp16_mul_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*16-1:0]  req_a,
    input  logic [NUM_REQ*16-1:0]  req_b,
    input  logic [NUM_REQ-1:0]     req_mode,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [FP16_W-1:0]      resp_data,
    output logic [ID_W-1:0]        resp_id
`ifdef FP_MUL_PERF_CNT_EN
    ,
    output logic [31:0]            perf_ops,
    output logic [31:0]            perf_stall
`endif
);

    logic [ID_W-1:0]   r_ptr;
    logic              r_s1_valid;
    mul_op_t           r_s1_op;
    logic [ID_W-1:0]   r_s1_id;
    logic              r_resp_valid;
    logic [FP16_W-1:0] r_resp_data;
    logic [ID_W-1:0]   r_resp_id;

    logic              w_advance;
    logic              w_s1_accept;
    logic              w_found;
    logic [ID_W-1:0]   w_win;
    logic              w_hs;
    mul_op_t           w_new_op;
    logic [FP16_W-1:0] w_core_res;

    assign w_advance   = !r_resp_valid || resp_ready;
    assign w_s1_accept = !r_s1_valid || w_advance;

    // Search starts one past the last winner and wraps, so every requester is reached.
    always_comb begin
        int unsigned idx;
        w_found = 1'b0;
        w_win   = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            idx = (32'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = ID_W'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && w_found && w_s1_accept) begin
            req_ready[w_win] = 1'b1;
        end
    end

    assign w_hs          = rst_n && w_found && w_s1_accept;
    assign w_new_op.a    = req_a[32'(w_win)*16 +: 16];
    assign w_new_op.b    = req_b[32'(w_win)*16 +: 16];
    assign w_new_op.mode = req_mode[w_win];

    int_fp_mul_core u_core (
        .i_mode   (r_s1_op.mode),
        .i_a      (r_s1_op.a),
        .i_b      (r_s1_op.b),
        .o_result (w_core_res)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr        <= ID_W'(NUM_REQ - 1);
            r_s1_valid   <= 1'b0;
            r_s1_op      <= '0;
            r_s1_id      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_id    <= '0;
        end else begin
            if (w_advance) begin
                r_resp_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_resp_data <= w_core_res;
                    r_resp_id   <= r_s1_id;
                end
            end
            // a grant in the same cycle as a shift refills S1 without a bubble
            if (w_hs) begin
                r_s1_valid <= 1'b1;
                r_s1_op    <= w_new_op;
                r_s1_id    <= w_win;
                r_ptr      <= w_win;
            end else if (w_advance) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    assign resp_valid = r_resp_valid;
    assign resp_data  = r_resp_data;
    assign resp_id    = r_resp_id;

`ifdef FP_MUL_PERF_CNT_EN
    logic [31:0] r_perf_ops;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_perf_ops   <= '0;
            r_perf_stall <= '0;
        end else begin
            if (w_hs) begin
                r_perf_ops <= r_perf_ops + 32'd1;
            end
            if (r_resp_valid && !resp_ready) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign perf_ops   = r_perf_ops;
    assign perf_stall = r_perf_stall;
`endif

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// Scoreboard bench for fp16_mul_arbiter: directed vectors, decoupled driver/monitor.
module tb_fp16_mul_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [63:0] req_a;
    logic [63:0] req_b;
    logic [3:0]  req_mode;
    logic        resp_valid;
    logic        resp_ready;
    logic [15:0] resp_data;
    logic [1:0]  resp_id;
`ifdef FP_MUL_PERF_CNT_EN
    logic [31:0] perf_ops;
    logic [31:0] perf_stall;
`endif

    fp16_mul_arbiter #(.NUM_REQ(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_mode   (req_mode),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_id    (resp_id)
`ifdef FP_MUL_PERF_CNT_EN
        ,
        .perf_ops   (perf_ops),
        .perf_stall (perf_stall)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        mode;
        logic [15:0] exp;
    } op_t;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  id;
        int unsigned cyc;
        bit          lat;
    } exp_t;

    op_t         rq[4][$];
    exp_t        sb[$];
    int          grant_log[$];
    bit          popflag[4];
    bit          lat_en;
    int unsigned cyc;
    int          checks;
    int          errors;
    bit          stalled;
    logic [15:0] held_data;
    logic [1:0]  held_id;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever @(posedge clk) cyc++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, required completion");
        $fatal(1, "watchdog");
    end

    // requester driver: present the head of each queue, retire it after a handshake
    initial begin
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_mode  = '0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                if (popflag[i]) begin
                    popflag[i] = 1'b0;
                    if (rq[i].size() > 0) rq[i].delete(0);
                end
                if (rq[i].size() > 0) begin
                    req_valid[i]      = 1'b1;
                    req_a[16*i +: 16] = rq[i][0].a;
                    req_b[16*i +: 16] = rq[i][0].b;
                    req_mode[i]       = rq[i][0].mode;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // handshake detector: pushes expected responses in grant order
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (req_ready != '0) begin
                    checks++;
                    if ($countones(req_ready) != 1) begin
                        errors++;
                        $display("FAIL ready_onehot: got %b, required one-hot or zero", req_ready);
                    end
                end
                for (int i = 0; i < 4; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        sb.push_back('{rq[i][0].exp, 2'(i), cyc, lat_en});
                        grant_log.push_back(i);
                        popflag[i] = 1'b1;
                    end
                end
            end
        end
    end

    // response monitor
    initial begin
        exp_t e;
        stalled = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && resp_valid) begin
                if (resp_ready) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_resp: got data=%h id=%0d, required no response",
                                 resp_data, resp_id);
                    end else begin
                        e = sb.pop_front();
                        if (resp_data !== e.data || resp_id !== e.id) begin
                            errors++;
                            $display("FAIL resp: got data=%h id=%0d, required data=%h id=%0d",
                                     resp_data, resp_id, e.data, e.id);
                        end
                        if (e.lat) begin
                            checks++;
                            if (cyc != e.cyc + 2) begin
                                errors++;
                                $display("FAIL latency: got %0d cycles, required 2", cyc - e.cyc);
                            end
                        end
                    end
                    stalled = 1'b0;
                end else begin
                    if (stalled) begin
                        checks++;
                        if (resp_data !== held_data || resp_id !== held_id) begin
                            errors++;
                            $display("FAIL stall_hold: got data=%h id=%0d, required data=%h id=%0d",
                                     resp_data, resp_id, held_data, held_id);
                        end
                    end
                    stalled   = 1'b1;
                    held_data = resp_data;
                    held_id   = resp_id;
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic add(input int i, input logic [15:0] a, input logic [15:0] b,
                       input logic mode, input logic [15:0] exp);
        rq[i].push_back('{a, b, mode, exp});
    endtask

    function automatic bit pending();
        pending = (sb.size() != 0);
        for (int i = 0; i < 4; i++) if (rq[i].size() != 0) pending = 1'b1;
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (pending() && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (pending()) begin
            errors++;
            $display("FAIL %s_timeout: got %0d outstanding, required 0", name, sb.size());
        end
        repeat (3) step();
    endtask

    task automatic clear_all();
        for (int i = 0; i < 4; i++) begin
            rq[i].delete();
            popflag[i] = 1'b0;
        end
        sb.delete();
        grant_log.delete();
    endtask

    task automatic apply_reset();
        clear_all();
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
    endtask

    initial begin
        int order[8];
        checks     = 0;
        errors     = 0;
        lat_en     = 1'b1;
        rst_n      = 1'b0;
        resp_ready = 1'b1;

        // reset values, with a request already waiting
        add(0, 16'h4200, 16'h4100, 1'b1, 16'h4780);
        repeat (2) step();
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", 32'(resp_data), 32'h0);
        chk("rst_resp_id", 32'(resp_id), 32'h0);
        rst_n = 1'b1;
        drain("single_fp");

        add(1, 16'h00FD, 16'h0004, 1'b0, 16'hFFF4);
        drain("single_int");

        add(2, 16'h7BFF, 16'h4000, 1'b1, 16'h7C00);
        add(2, 16'h7C00, 16'h0000, 1'b1, 16'h7E00);
        add(2, 16'h3C00, 16'h8000, 1'b1, 16'h8000);
        add(2, 16'h7D00, 16'h3C00, 1'b1, 16'h7E00);
        add(2, 16'hFC00, 16'h4000, 1'b1, 16'hFC00);
        add(2, 16'h3E00, 16'h3C01, 1'b1, 16'h3E02);
        add(2, 16'h3C03, 16'h3E00, 1'b1, 16'h3E04);
        add(2, 16'h0200, 16'h4000, 1'b1, 16'h0000);
        add(2, 16'h8001, 16'h3C00, 1'b1, 16'h8000);
        add(2, 16'hC000, 16'hC000, 1'b1, 16'h4400);
        drain("special");

        // fairness: all four valid continuously
        apply_reset();
        add(0, 16'h0002, 16'h0003, 1'b0, 16'h0006);
        add(0, 16'h0080, 16'h0080, 1'b0, 16'h4000);
        add(1, 16'h00FF, 16'h00FF, 1'b0, 16'h0001);
        add(1, 16'h007F, 16'h007F, 1'b0, 16'h3F01);
        add(2, 16'h007F, 16'h0080, 1'b0, 16'hC080);
        add(2, 16'h3C00, 16'h4000, 1'b1, 16'h4000);
        add(3, 16'h4500, 16'h4500, 1'b1, 16'h4E40);
        add(3, 16'hAB03, 16'h12FE, 1'b0, 16'hFFFA);
        drain("fairness");
        order = '{0, 1, 2, 3, 0, 1, 2, 3};
        chk("fair_count", 32'(grant_log.size()), 32'd8);
        for (int k = 0; k < 8 && k < grant_log.size(); k++) begin
            chk($sformatf("fair_grant%0d", k), 32'(grant_log[k]), 32'(order[k]));
        end

        // backpressure
        apply_reset();
        lat_en     = 1'b0;
        resp_ready = 1'b0;
        add(0, 16'h3C00, 16'h3C00, 1'b1, 16'h3C00);
        add(1, 16'h0005, 16'h00FF, 1'b0, 16'hFFFB);
        add(2, 16'hC000, 16'h3800, 1'b1, 16'hBC00);
        repeat (6) step();
        chk("bp_in_flight", 32'(sb.size()), 32'd2);
        chk("bp_ready_blocked", 32'(req_ready), 32'h0);
        chk("bp_resp_valid", 32'(resp_valid), 32'h1);
        chk("bp_resp_id", 32'(resp_id), 32'h0);
        resp_ready = 1'b1;
        drain("backpressure");
        chk("bp_total_grants", 32'(grant_log.size()), 32'd3);

        // reset with S1 and S2 both full
        apply_reset();
        resp_ready = 1'b0;
        add(0, 16'h0001, 16'h0001, 1'b0, 16'h0001);
        add(1, 16'h0002, 16'h0002, 1'b0, 16'h0004);
        add(3, 16'h0003, 16'h0003, 1'b0, 16'h0009);
        repeat (6) step();
        chk("mid_full_valid", 32'(resp_valid), 32'h1);
        chk("mid_full_count", 32'(sb.size()), 32'd2);
        clear_all();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(resp_valid), 32'h0);
        chk("mid_rst_data", 32'(resp_data), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        repeat (2) step();
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        lat_en     = 1'b1;
        add(2, 16'h4000, 16'h4000, 1'b1, 16'h4400);
        drain("post_reset");
        chk("post_reset_grants", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() > 0) chk("post_reset_winner", 32'(grant_log[0]), 32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
